quad_step_decoder: RTL and testbench

- Upstream front-end for the N-bit up/down counter; converts raw asynchronous quadrature signals (A/B) from an encoder into counter controls.
- Synchronizes and glitch-filters A/B, then decodes Gray-code transitions.
- Produces a one-cycle `step` pulse and a `dir` level: `step` gates the counter's advance, `dir` drives its `mode` (1 = up, 0 = down).
- Detects and counts illegal transitions.

---
 rtl/quad_step_decoder.sv | 164 ++++++++++++++++
 tb/tb_quad_step_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature front-end: synchronises and glitch-filters raw A/B encoder channels,
// then decodes Gray-code transitions into step/dir pulses and counts illegal jumps.
module quad_step_decoder #(
    parameter int FILT_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr_err,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0]       FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [8:0]       BLANK_LEN = 9'(FILT_LEN + 3);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    // Saturating increment for the illegal-transition counter
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
        logic [ERR_W-1:0] res;
        if (val == ERR_MAX) begin
            res = val;
        end else begin
            res = val + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // Channel vectors are {A, B}
    logic [1:0]      sync1_q, sync_q;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][7:0] fc_q, fc_d;
    logic [1:0]      prev_q;
    logic [8:0]      startup_q, startup_d;
    logic            blank_s;
    logic            raw_step_q, raw_step_d;
    logic            raw_up_q, raw_up_d;
    logic            raw_err_q, raw_err_d;
    logic            step_q, step_d;
    logic            err_q, err_d;
    logic            dir_q, dir_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    // Per-channel filter: a new level is accepted after FILT_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        fc_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (fc_q[i] == FILT_LAST) begin
                    filt_d[i] = sync_q[i];
                    fc_d[i]   = 8'd0;
                end else begin
                    fc_d[i] = fc_q[i] + 8'd1;
                end
            end else begin
                fc_d[i] = 8'd0;
            end
        end
    end

    assign blank_s = (startup_q < BLANK_LEN);

    // Startup blanking counter and Gray-code transition classification
    always_comb begin
        startup_d  = startup_q;
        raw_step_d = 1'b0;
        raw_up_d   = raw_up_q;
        raw_err_d  = 1'b0;
        if (blank_s) begin
            startup_d = startup_q + 9'd1;
        end else begin
            startup_d = startup_q;
        end
        case ({prev_q, filt_q})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                raw_step_d = 1'b1;
                raw_up_d   = 1'b1;
            end
            4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                raw_step_d = 1'b1;
                raw_up_d   = 1'b0;
            end
            4'b0011, 4'b1100, 4'b1001, 4'b0110: begin
                raw_err_d = 1'b1;
            end
            default: begin
                raw_step_d = 1'b0;
                raw_err_d  = 1'b0;
            end
        endcase
        if (blank_s) begin
            raw_step_d = 1'b0;
            raw_up_d   = raw_up_q;
            raw_err_d  = 1'b0;
        end else begin
            raw_up_d = raw_step_d ? raw_up_d : raw_up_q;
        end
    end

    // Output stage: enable gates pulses only, dir keeps tracking legal moves
    always_comb begin
        step_d = raw_step_q & enable;
        err_d  = raw_err_q & enable;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        if (raw_step_q) begin
            dir_d = raw_up_q;
        end else begin
            dir_d = dir_q;
        end
        if (clr_err) begin
            cnt_d = '0;
        end else if (err_d) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 2'b00;
            sync_q     <= 2'b00;
            filt_q     <= 2'b00;
            fc_q       <= '0;
            prev_q     <= 2'b00;
            startup_q  <= 9'd0;
            raw_step_q <= 1'b0;
            raw_up_q   <= 1'b0;
            raw_err_q  <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= {a_in, b_in};
            sync_q     <= sync1_q;
            filt_q     <= filt_d;
            fc_q       <= fc_d;
            prev_q     <= filt_q;
            startup_q  <= startup_d;
            raw_step_q <= raw_step_d;
            raw_up_q   <= raw_up_d;
            raw_err_q  <= raw_err_d;
            step_q     <= step_d;
            err_q      <= err_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
        end
    end

    assign step    = step_q;
    assign err     = err_q;
    assign dir     = dir_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus randomized encoder motion,
// checked every cycle against a window/Gray-arithmetic reference model.
module tb_quad_step_decoder;

    localparam int FILT_LEN = 4;
    localparam int ERR_W    = 2;
    localparam int BLANK    = FILT_LEN + 3;
    localparam int CNT_MAX  = (1 << ERR_W) - 1;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             enable  = 1'b1;
    logic             a_in    = 1'b1;
    logic             b_in    = 1'b1;
    logic             clr_err = 1'b0;
    logic             step, dir, err;
    logic [ERR_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int steps_seen = 0;
    int errs_seen  = 0;
    int net        = 0;

    quad_step_decoder #(.FILT_LEN(FILT_LEN), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .a_in(a_in), .b_in(b_in),
        .clr_err(clr_err), .step(step), .dir(dir), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit ina[$], inb[$], sya[$], syb[$], fa[$], fb[$];
    int e;
    bit pr_step, pr_up, pr_err;
    bit m_step, m_err, m_dir;
    int m_cnt;

    function automatic int gidx(input bit a, input bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // true when the last FILT_LEN synchronised samples of a channel all equal val
    function automatic bit run_full(input bit ch, input bit val);
        for (int k = 0; k < FILT_LEN; k++) begin
            int idx;
            bit s;
            idx = e - k;
            s = (idx < 0) ? 1'b0 : (ch ? syb[idx] : sya[idx]);
            if (s != val) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        ina.delete(); inb.delete(); sya.delete(); syb.delete(); fa.delete(); fb.delete();
        e = 0;
        pr_step = 0; pr_up = 0; pr_err = 0;
        m_step = 0; m_err = 0; m_dir = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit sa, sb, pa, pb, qa, qb, na, nb, r_step, r_up, r_err;
        int d;
        ina.push_back(a_in);
        inb.push_back(b_in);
        sa = (e >= 2) ? ina[e-2] : 1'b0;
        sb = (e >= 2) ? inb[e-2] : 1'b0;
        sya.push_back(sa);
        syb.push_back(sb);
        pa = (e >= 1) ? fa[e-1] : 1'b0;
        pb = (e >= 1) ? fb[e-1] : 1'b0;
        qa = (e >= 2) ? fa[e-2] : 1'b0;
        qb = (e >= 2) ? fb[e-2] : 1'b0;
        na = run_full(1'b0, !pa) ? !pa : pa;
        nb = run_full(1'b1, !pb) ? !pb : pb;
        d = (gidx(pa, pb) - gidx(qa, qb)) & 3;
        r_step = (e >= BLANK) && (d == 1 || d == 3);
        r_up   = (d == 1);
        r_err  = (e >= BLANK) && (d == 2);
        m_step = pr_step && enable;
        m_err  = pr_err && enable;
        if (pr_step) m_dir = pr_up;
        if (clr_err) m_cnt = 0;
        else if (m_err && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        pr_step = r_step;
        pr_up   = r_up;
        pr_err  = r_err;
        fa.push_back(na);
        fb.push_back(nb);
        e++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_edge();
        end
    end

    // per-cycle compare against the model, plus pulse bookkeeping for directed checks
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_step", step, 0);
                chk("rst_err", err, 0);
                chk("rst_dir", dir, 0);
                chk("rst_cnt", err_cnt, 0);
            end else begin
                chk("step", step, m_step);
                chk("err", err, m_err);
                chk("dir", dir, m_dir);
                chk("err_cnt", err_cnt, m_cnt);
                if (step) begin
                    steps_seen++;
                    net = (net + (dir ? 1 : 15)) % 16;
                end
                if (err) errs_seen++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_ab(input bit a, input bit b, input int hold);
        a_in = a;
        b_in = b;
        cyc(hold);
    endtask

    task automatic set_pos(input int p);
        case (p & 3)
            0:       begin a_in = 1'b0; b_in = 1'b0; end
            1:       begin a_in = 1'b1; b_in = 1'b0; end
            2:       begin a_in = 1'b1; b_in = 1'b1; end
            default: begin a_in = 1'b0; b_in = 1'b1; end
        endcase
    endtask

    initial begin
        // 1: reset with encoder resting at 11, then blanking
        cyc(2);
        reset = 1'b0;
        steps_seen = 0;
        errs_seen  = 0;
        cyc(20);
        chk("blank_steps", steps_seen, 0);
        chk("blank_errs", errs_seen, 0);
        chk("blank_cnt", err_cnt, 0);
        chk("blank_dir", dir, 0);
        set_ab(1'b0, 1'b1, 12);
        set_ab(1'b0, 1'b0, 12);

        // 2: forward rotation with latency pin
        steps_seen = 0;
        net = 0;
        a_in = 1'b1;
        cyc(7);
        chk("lat_before", step, 0);
        cyc(1);
        chk("lat_step", step, 1);
        chk("lat_dir", dir, 1);
        cyc(4);
        set_ab(1'b1, 1'b1, 12);
        set_ab(1'b0, 1'b1, 12);
        set_ab(1'b0, 1'b0, 12);
        chk("fwd_steps", steps_seen, 4);
        chk("fwd_dir", dir, 1);
        chk("fwd_cnt", err_cnt, 0);
        chk("fwd_net", net, 4);

        // 3: reverse rotation
        steps_seen = 0;
        set_ab(1'b0, 1'b1, 12);
        set_ab(1'b1, 1'b1, 12);
        set_ab(1'b1, 1'b0, 12);
        set_ab(1'b0, 1'b0, 12);
        chk("rev_steps", steps_seen, 4);
        chk("rev_dir", dir, 0);
        chk("rev_net", net, 0);

        // 4: glitch rejection then just-long-enough pulse
        steps_seen = 0;
        errs_seen  = 0;
        set_ab(1'b1, 1'b0, 3);
        set_ab(1'b0, 1'b0, 20);
        chk("glitch_steps", steps_seen, 0);
        chk("glitch_errs", errs_seen, 0);
        set_ab(1'b1, 1'b0, 4);
        set_ab(1'b0, 1'b0, 20);
        chk("pulse_steps", steps_seen, 2);
        chk("pulse_dir", dir, 0);
        chk("pulse_errs", errs_seen, 0);

        // 5: illegal jumps, saturation, clear beats increment
        steps_seen = 0;
        errs_seen  = 0;
        set_ab(1'b1, 1'b1, 12);
        set_ab(1'b0, 1'b0, 12);
        set_ab(1'b1, 1'b1, 12);
        set_ab(1'b0, 1'b0, 12);
        set_ab(1'b1, 1'b1, 12);
        chk("ill_errs", errs_seen, 5);
        chk("ill_steps", steps_seen, 0);
        chk("ill_sat", err_cnt, CNT_MAX);
        a_in = 1'b0;
        b_in = 1'b0;
        for (int k = 0; k < 20 && !err; k++) cyc(1);
        chk("clr_err_seen", err, 1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("clr_cnt", err_cnt, 0);
        cyc(12);

        // 6: enable gating
        steps_seen = 0;
        enable = 1'b0;
        set_ab(1'b1, 1'b0, 12);
        set_ab(1'b1, 1'b1, 12);
        chk("dis_steps", steps_seen, 0);
        chk("dis_dir", dir, 1);
        enable = 1'b1;
        cyc(20);
        chk("reen_steps", steps_seen, 0);

        // 7: randomized motion, glitches, illegal jumps, enables, clears, resets
        for (int it = 0; it < 1500; it++) begin
            int p, r, hold;
            p = gidx(a_in, b_in);
            r = $urandom_range(0, 99);
            if (r < 40) p = p + 1;
            else if (r < 75) p = p + 3;
            else if (r < 83) p = p + 2;
            hold = $urandom_range(1, 10);
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                cyc(2);
                reset = 1'b0;
            end
            set_pos(p);
            clr_err = ($urandom_range(0, 14) == 0);
            cyc(1);
            clr_err = 1'b0;
            if (hold > 1) cyc(hold - 1);
        end
        cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
